// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU widths, op codes and arbiter state type
//
// Purpose: constants shared by alu, rr_arbiter and alu_share_arbiter.
// Contents: ALU_W / ALU_OP_W widths, ALU op encodings, arbiter FSM states.
package alu_pkg;

  localparam int ALU_W    = 32;
  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_LAND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_LOR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_LNOR = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 3'b101;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 3'b110;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU
//
// Purpose: single-cycle ALU shared by several requesters.
// Ports:
//   a, b    in  ALU_W     operands
//   op      in  ALU_OP_W  operation select (op 111 behaves as add)
//   result  out ALU_W     result, mod 2^ALU_W
//   zero    out 1         result == 0
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]    a,
  input  logic [ALU_W-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [ALU_W-1:0]    result,
  output logic                zero
);

  logic a_nz;
  logic b_nz;

  assign a_nz = |a;
  assign b_nz = |b;

  always_comb begin
    result = '0;
    case (op)
      ALU_SUB:  result = a - b;
      // Logical ops yield a 0/1 result, not a bitwise one.
      ALU_LAND: result = {{(ALU_W-1){1'b0}}, a_nz & b_nz};
      ALU_LOR:  result = {{(ALU_W-1){1'b0}}, a_nz | b_nz};
      ALU_LNOR: result = {{(ALU_W-1){1'b0}}, ~(a_nz | b_nz)};
      ALU_XOR:  result = a ^ b;
      ALU_SLTU: result = {{(ALU_W-1){1'b0}}, a < b};
      default:  result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first requester after last_grant (wrapping mod NUM_REQ).
// Ports:
//   req         in  NUM_REQ  request vector
//   last_grant  in  ID_W     most recently granted index
//   enable      in  1        when low, grant is forced to zero
//   grant       out NUM_REQ  one-hot grant (zero when none or disabled)
//   grant_id    out ID_W     index of the winner (valid when any req set)
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int              idx;
  logic [ID_W-1:0] idx_w;
  logic            found;

  // Search order last_grant+1 .. last_grant+NUM_REQ, so the previous winner
  // is checked last and cannot win twice while others are waiting.
  always_comb begin
    idx      = 0;
    idx_w    = '0;
    found    = 1'b0;
    grant_id = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = ID_W'(idx);
      if (!found && req[idx_w]) begin
        found    = 1'b1;
        grant_id = idx_w;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found && enable) begin
      grant[grant_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU among NUM_REQ requesters
//
// Purpose: round-robin accepts one operand/op transaction per cycle, registers
// the ALU result/zero flag and returns it to the owning requester.
// Ports:
//   clk, rst    in   clock, asynchronous active-high reset
//   req_valid   in   NUM_REQ        per-requester transaction valid
//   req_ready   out  NUM_REQ        per-requester accept (one-hot or zero)
//   req_a/b     in   NUM_REQ*32     operands, requester i at [32i+31:32i]
//   req_op      in   NUM_REQ*3      op, requester i at [3i+2:3i]
//   rsp_valid   out  NUM_REQ        result pending for owner (one-hot or zero)
//   rsp_ready   in   NUM_REQ        requester takes result (owner bit only)
//   rsp_result  out  32             registered ALU result
//   rsp_zero    out  1              registered ALU zero flag
//   owner_id    out  ID_W           owner of the pending response
//   busy        out  1              response pending
//   ops_done    out  CNT_W          completed response handshakes, wraps
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ALU_W-1:0]    req_a,
  input  logic [NUM_REQ*ALU_W-1:0]    req_b,
  input  logic [NUM_REQ*ALU_OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]          rsp_valid,
  input  logic [NUM_REQ-1:0]          rsp_ready,
  output logic [ALU_W-1:0]            rsp_result,
  output logic                        rsp_zero,
  output logic [ID_W-1:0]             owner_id,
  output logic                        busy,
  output logic [CNT_W-1:0]            ops_done
);

  arb_state_e          state;
  logic [ID_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                rsp_hs;
  logic                accept_ok;
  logic                accept;
  logic [ALU_W-1:0]    a_sel;
  logic [ALU_W-1:0]    b_sel;
  logic [ALU_OP_W-1:0] op_sel;
  logic [ALU_W-1:0]    alu_result;
  logic                alu_zero;

  // Taking the response frees the result register in the same cycle, which
  // is what allows one accept per cycle back-to-back.
  assign rsp_hs    = (state == ST_RESP) && rsp_ready[owner_id];
  assign accept_ok = (state == ST_IDLE) || rsp_hs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (accept_ok),
    .grant      (grant),
    .grant_id   (grant_id)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    a_sel  = req_a[grant_id*ALU_W +: ALU_W];
    b_sel  = req_b[grant_id*ALU_W +: ALU_W];
    op_sel = req_op[grant_id*ALU_OP_W +: ALU_OP_W];
  end

  alu u_alu (
    .a      (a_sel),
    .b      (b_sel),
    .op     (op_sel),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      owner_id   <= '0;
      busy       <= 1'b0;
      ops_done   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (rsp_hs) begin
        ops_done <= ops_done + CNT_W'(1);
      end
      if (accept) begin
        state      <= ST_RESP;
        busy       <= 1'b1;
        rsp_valid  <= grant;
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        owner_id   <= grant_id;
        last_grant <= grant_id;
      end else if (rsp_hs) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*3-1:0]  req_op;
  logic [N-1:0]  rsp_valid;
  logic [N-1:0]  rsp_ready;
  logic [31:0]   rsp_result;
  logic          rsp_zero;
  logic [1:0]    owner_id;
  logic          busy;
  logic [15:0]   ops_done;

  alu_share_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .owner_id   (owner_id),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // Stimulus state
  logic        valid_v [N];
  logic [31:0] a_v [N];
  logic [31:0] b_v [N];
  logic [2:0]  op_v [N];
  logic [N-1:0] rr_v;

  // Behavioural model
  bit          m_pend;
  int          m_owner;
  int          m_last;
  logic [31:0] m_res;
  bit          m_zero;
  int          m_ops;
  logic [N-1:0] exp_ready;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd1:    return a - b;
      3'd2:    return (a != 0 && b != 0) ? 32'd1 : 32'd0;
      3'd3:    return (a != 0 || b != 0) ? 32'd1 : 32'd0;
      3'd4:    return (a != 0 || b != 0) ? 32'd0 : 32'd1;
      3'd5:    return a ^ b;
      3'd6:    return (a < b) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = valid_v[i];
      req_a[32*i +: 32]    = a_v[i];
      req_b[32*i +: 32]    = b_v[i];
      req_op[3*i +: 3]     = op_v[i];
    end
    rsp_ready = rr_v;
  endtask

  // Compare DUT to the model for this cycle, then advance the model across
  // the coming rising edge using the inputs currently applied.
  task automatic check_cycle();
    bit ok;
    bit hs;
    int g;
    int idx;
    if (rst) begin
      m_pend = 0; m_owner = 0; m_last = N - 1; m_res = 0; m_zero = 0; m_ops = 0;
      exp_ready = '0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_owner_id", 32'(owner_id), 32'd0);
      return;
    end
    ok = !m_pend || rr_v[m_owner];
    g = -1;
    if (ok) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last + k) % N;
        if (g < 0 && valid_v[idx]) g = idx;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("rsp_valid", 32'(rsp_valid), m_pend ? 32'(1 << m_owner) : 32'd0);
    chk("busy", 32'(busy), 32'(m_pend));
    chk("ops_done", 32'(ops_done), 32'(m_ops % 65536));
    if (m_pend) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_zero", 32'(rsp_zero), 32'(m_zero));
      chk("owner_id", 32'(owner_id), 32'(m_owner));
    end
    hs = m_pend && rr_v[m_owner];
    if (hs) m_ops++;
    if (g >= 0) begin
      m_res   = ref_alu(op_v[g], a_v[g], b_v[g]);
      m_zero  = (m_res == 0);
      m_pend  = 1;
      m_owner = g;
      m_last  = g;
    end else if (hs) begin
      m_pend = 0;
    end
  endtask

  task automatic at_neg();
    apply();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic all_idle();
    for (int i = 0; i < N; i++) begin
      valid_v[i] = 0; a_v[i] = 0; b_v[i] = 0; op_v[i] = 0;
    end
  endtask

  int exp_order [6] = '{0, 1, 2, 3, 0, 1};
  int got;
  int ops_snap;

  initial begin
    all_idle();
    rr_v = '0;
    rst = 1'b1;
    at_neg();
    to_pos();
    rst = 1'b0;

    // 1: add 5+7 from requester 0
    valid_v[0] = 1; a_v[0] = 5; b_v[0] = 7; op_v[0] = 3'b000; rr_v = 4'b0001;
    at_neg();
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    to_pos();
    valid_v[0] = 0;
    at_neg();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_zero", 32'(rsp_zero), 32'd0);
    to_pos();
    at_neg();
    chk("t1_ops_done", 32'(ops_done), 32'd1);
    to_pos();

    // 2: sub to zero, then sltu
    valid_v[1] = 1; a_v[1] = 32'h10; b_v[1] = 32'h10; op_v[1] = 3'b001; rr_v = 4'b0010;
    at_neg();
    to_pos();
    valid_v[1] = 0;
    at_neg();
    chk("t2_result", rsp_result, 32'd0);
    chk("t2_zero", 32'(rsp_zero), 32'd1);
    chk("t2_owner", 32'(owner_id), 32'd1);
    to_pos();
    valid_v[1] = 1; a_v[1] = 3; b_v[1] = 9; op_v[1] = 3'b110;
    at_neg();
    to_pos();
    valid_v[1] = 0;
    at_neg();
    chk("t2_sltu", rsp_result, 32'd1);
    to_pos();

    // 3: round-robin order from reset with everyone requesting
    rst = 1'b1;
    at_neg();
    to_pos();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      valid_v[i] = 1; a_v[i] = 32'(i * 3); b_v[i] = 32'd1; op_v[i] = 3'b000;
    end
    rr_v = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      at_neg();
      got = -1;
      for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
      chk("t3_rr_order", 32'(got), 32'(exp_order[k]));
      to_pos();
    end
    all_idle();
    at_neg(); to_pos();
    at_neg(); to_pos();

    // 4: wraparound add held under backpressure, req0 waits
    valid_v[2] = 1; a_v[2] = 32'hFFFF_FFFF; b_v[2] = 32'd1; op_v[2] = 3'b000; rr_v = 4'b0000;
    at_neg();
    to_pos();
    valid_v[2] = 0;
    valid_v[0] = 1; a_v[0] = 32'd100; b_v[0] = 32'd1; op_v[0] = 3'b001;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t4_req_ready", 32'(req_ready), 32'd0);
      chk("t4_result", rsp_result, 32'd0);
      chk("t4_zero", 32'(rsp_zero), 32'd1);
      to_pos();
    end
    rr_v = 4'b0100;
    at_neg();
    chk("t4_req_ready_rise", 32'(req_ready), 32'h1);
    to_pos();
    valid_v[0] = 0; rr_v = 4'b0001;
    at_neg();
    chk("t4_next_result", rsp_result, 32'd99);
    to_pos();
    at_neg(); to_pos();

    // 5: rsp_ready on non-owner bits only
    valid_v[1] = 1; a_v[1] = 32'd8; b_v[1] = 32'd8; op_v[1] = 3'b101; rr_v = 4'b0000;
    at_neg();
    to_pos();
    valid_v[1] = 0; rr_v = 4'b1101;
    ops_snap = m_ops;
    for (int k = 0; k < 2; k++) begin
      at_neg();
      chk("t5_ops_hold", 32'(ops_done), 32'(ops_snap));
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h2);
      to_pos();
    end
    rr_v = 4'b1111;
    at_neg(); to_pos();

    // 6: asynchronous reset mid-cycle while a response is pending
    valid_v[0] = 1; a_v[0] = 32'd1; b_v[0] = 32'd2; op_v[0] = 3'b000; rr_v = 4'b0000;
    at_neg();
    to_pos();
    valid_v[0] = 0;
    apply();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    at_neg();
    to_pos();
    rst = 1'b0;
    valid_v[3] = 1; a_v[3] = 32'd4; b_v[3] = 32'd4; op_v[3] = 3'b000;
    valid_v[0] = 1; a_v[0] = 32'd6; b_v[0] = 32'd6; op_v[0] = 3'b000;
    rr_v = 4'b1111;
    at_neg();
    chk("t6_first_grant", 32'(req_ready), 32'h1);
    chk("t6_ops_done", 32'(ops_done), 32'd0);
    to_pos();

    // Random phase: protocol-respecting requesters, random response backpressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (valid_v[i] && !exp_ready[i]) begin
          if ($urandom_range(0, 15) == 0) valid_v[i] = 0;
        end else begin
          valid_v[i] = 1'($urandom_range(0, 1));
          a_v[i]     = rand_opnd();
          b_v[i]     = rand_opnd();
          op_v[i]    = 3'($urandom_range(0, 7));
        end
      end
      for (int i = 0; i < N; i++) rr_v[i] = ($urandom_range(0, 3) != 0);
      at_neg();
      to_pos();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
